if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, imem request, IF/ID register, stall hold buffer.
// Define DELAY_SLOT_EN to give taken branches a single delay slot.
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_pause,
  input  logic        ii_pause,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        mem_conflict,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] id_inst,
  output logic [15:0] id_pc,
  output logic        id_valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] buf_inst, buf_inst_n;
  logic [15:0] buf_pc, buf_pc_n;
  logic [15:0] inst_n, idpc_n;
  logic        valid_n;
  logic        stall, got, dlv;
  logic [15:0] dlv_inst, dlv_pc, pc_inc;
`ifdef DELAY_SLOT_EN
  logic        pend_v, pend_v_n;
  logic [15:0] pend_pc, pend_pc_n;
  logic        redirect;
  logic [15:0] tgt;
`endif

  assign stall      = PC_pause | ii_pause;
  assign imem_rd    = !rst && (state != HOLD) && !mem_conflict;
  assign imem_addr  = pc;
  assign fetch_busy = (state == WAIT);
  assign got        = imem_rd & imem_ready;
  assign pc_inc     = pc + 16'd1;

  // Next-state: deliver, buffer or bubble, then apply any redirect.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    buf_inst_n = buf_inst;
    buf_pc_n   = buf_pc;
    inst_n     = id_inst;
    idpc_n     = id_pc;
    valid_n    = id_valid;
    dlv        = 1'b0;
    dlv_inst   = imem_data;
    dlv_pc     = pc_inc;
`ifdef DELAY_SLOT_EN
    pend_v_n   = pend_v;
    pend_pc_n  = pend_pc;
    redirect   = pend_v | branch_taken;
    tgt        = pend_v ? pend_pc : branch_target;
`endif
    case (state)
      HOLD: begin
        if (!stall) begin
          dlv      = 1'b1;
          dlv_inst = buf_inst;
          dlv_pc   = buf_pc;
        end
      end
      default: begin
        if (got) begin
          if (!stall) begin
            dlv = 1'b1;
          end else begin
            buf_inst_n = imem_data;
            buf_pc_n   = pc_inc;
            state_n    = HOLD;
          end
        end else begin
          state_n = WAIT;
          if (!ii_pause) begin
            inst_n  = NOP_INST;
            valid_n = 1'b0;
          end
        end
      end
    endcase
    if (dlv) begin
      inst_n  = dlv_inst;
      idpc_n  = dlv_pc;
      valid_n = 1'b1;
      pc_n    = dlv_pc;
      state_n = FETCH;
    end
`ifdef DELAY_SLOT_EN
    if (redirect) begin
      if (dlv) begin
        pc_n     = tgt;
        pend_v_n = 1'b0;
      end else begin
        pend_v_n  = 1'b1;
        pend_pc_n = tgt;
      end
    end
`else
    if (branch_taken) begin
      pc_n       = branch_target;
      state_n    = FETCH;
      buf_inst_n = 16'h0000;
      buf_pc_n   = 16'h0000;
      inst_n     = NOP_INST;
      valid_n    = 1'b0;
    end
`endif
  end

  // State, PC, hold buffer and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      buf_inst <= 16'h0000;
      buf_pc   <= 16'h0000;
      id_inst  <= NOP_INST;
      id_pc    <= 16'h0000;
      id_valid <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_v   <= 1'b0;
      pend_pc  <= 16'h0000;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      buf_inst <= buf_inst_n;
      buf_pc   <= buf_pc_n;
      id_inst  <= inst_n;
      id_pc    <= idpc_n;
      id_valid <= valid_n;
`ifdef DELAY_SLOT_EN
      pend_v   <= pend_v_n;
      pend_pc  <= pend_pc_n;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic
// checked against a transaction-level fetch model.
module tb_if_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_pause = 1'b0;
  logic        ii_pause = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        mem_conflict = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  // model state
  logic [15:0] m_pc;
  logic        m_have_buf;
  logic [15:0] m_buf_inst, m_buf_pc;
  logic        m_waiting;
  logic [15:0] m_pend[$];
  logic [15:0] m_inst, m_idpc;
  logic        m_valid;

  if_fetch_stage dut (
    .clk(clk), .rst(rst),
    .PC_pause(PC_pause), .ii_pause(ii_pause),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_conflict(mem_conflict),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = RST_PC;
    m_have_buf = 1'b0;
    m_buf_inst = 16'h0000;
    m_buf_pc = 16'h0000;
    m_waiting = 1'b0;
    m_pend.delete();
    m_inst = NOP;
    m_idpc = 16'h0000;
    m_valid = 1'b0;
  endtask

  // One cycle: drive, check against the model, advance the model, clock.
  task automatic cyc(input logic r, input logic pp, input logic ip,
                     input logic br, input logic [15:0] tg,
                     input logic mc, input logic rdy);
    logic        e_rd, hz, given, have_tg;
    logic [15:0] g_inst, g_pc, tgv;
    rst = r; PC_pause = pp; ii_pause = ip;
    branch_taken = br; branch_target = tg;
    mem_conflict = mc; imem_ready = rdy;
    imem_data = 16'($urandom);
    #1;
    e_rd = !r && !m_have_buf && !mc;
    chk("imem_rd", {15'd0, imem_rd}, {15'd0, e_rd});
    chk("imem_addr", imem_addr, m_pc);
    chk("fetch_busy", {15'd0, fetch_busy}, {15'd0, m_waiting});
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_idpc);
    chk("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
    hz = pp | ip;
    given = 1'b0;
    g_inst = 16'h0000;
    g_pc = 16'h0000;
    if (r) begin
      m_reset();
    end else begin
      if (m_have_buf) begin
        if (!hz) begin
          given = 1'b1;
          g_inst = m_buf_inst;
          g_pc = m_buf_pc;
          m_have_buf = 1'b0;
        end
      end else if (e_rd && rdy) begin
        m_waiting = 1'b0;
        if (!hz) begin
          given = 1'b1;
          g_inst = imem_data;
          g_pc = m_pc + 16'd1;
        end else begin
          m_have_buf = 1'b1;
          m_buf_inst = imem_data;
          m_buf_pc = m_pc + 16'd1;
        end
      end else begin
        m_waiting = 1'b1;
        if (!ip) begin
          m_inst = NOP;
          m_valid = 1'b0;
        end
      end
      if (given) begin
        m_inst = g_inst;
        m_idpc = g_pc;
        m_valid = 1'b1;
        m_pc = g_pc;
        m_waiting = 1'b0;
      end
`ifdef DELAY_SLOT_EN
      have_tg = (m_pend.size() != 0) || br;
      tgv = (m_pend.size() != 0) ? m_pend[0] : tg;
      if (have_tg) begin
        if (given) begin
          m_pc = tgv;
          m_pend.delete();
        end else if (m_pend.size() == 0) begin
          m_pend.push_back(tgv);
        end
      end
`else
      have_tg = br;
      tgv = tg;
      if (have_tg) begin
        m_pc = tgv;
        m_have_buf = 1'b0;
        m_waiting = 1'b0;
        m_inst = NOP;
        m_valid = 1'b0;
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic pp, input logic ip,
                     input logic mc, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, pp, ip, 1'b0, 16'h0, mc, rdy);
  endtask

  initial begin
    logic pp, ip, br, mc, rdy, r;
    int   sel;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 16'h0000);
    chk("rst_id_valid", {15'd0, id_valid}, 16'h0000);
    // streaming after reset
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      chk("stream_addr", imem_addr, 16'(k));
      chk("stream_id_pc", id_pc, 16'(k));
      chk("stream_valid", {15'd0, id_valid}, 16'h0001);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    // stall into HOLD for 2 cycles, then release
    run(2, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0, 1'b1);
    // single-sided pauses
    run(2, 1'b1, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);
    // mem_conflict bubble
    run(1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);
    // slow memory, then stall during wait
    run(3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, 1'b1);
    // branch with word ready, and branch while waiting
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    chk("br_addr", imem_addr, 16'h0040);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      pp = (sel < 20) || (sel >= 95);
      ip = (sel < 20) || (sel >= 90 && sel < 95);
      br = ($urandom_range(0, 9) == 0);
      mc = ($urandom_range(0, 6) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 59) == 0);
      cyc(r, pp, ip, br, 16'($urandom), mc, rdy);
    end
    // pc wrap, then reset while waiting
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    chk("wrap_addr0", imem_addr, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("wrap_id_pc", id_pc, 16'h0000);
    chk("wrap_addr1", imem_addr, 16'h0000);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_busy", {15'd0, fetch_busy}, 16'h0001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_wait_addr", imem_addr, RST_PC);
    chk("rst_wait_busy", {15'd0, fetch_busy}, 16'h0000);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
